edac_encode_pipe: RTL

- Parametrised, handshaked successor of the 4-bit CRC+Hamming EDAC encoder.
- Accepts a DATA_W-bit word and computes a CRC_W-bit CRC bit-serially, one division step per cycle.
- Hamming-encodes the {data, crc} message, optionally adding an overall SECDED parity bit.
- Sits between the producer of protected data and the storage/transmit path, with valid/ready on both sides.

---
 rtl/edac_encode_pipe_if.sv | 17 +
 rtl/edac_encode_pipe.sv | 115 +++++++++++
 2 files changed

// File: rtl/edac_encode_pipe_if.sv
// edac_encode_pipe_if: valid/ready bundle between producer, encoder and consumer
// in_valid/in_ready/din : payload handshake into the encoder
// out_valid/out_ready/dout : codeword handshake out of the encoder
// master = producer/consumer side, slave = encoder side
interface edac_encode_pipe_if #(
    parameter int DATA_W = 4,
    parameter int OUT_W  = 16
);
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] din;
    logic              out_valid;
    logic              out_ready;
    logic [OUT_W-1:0]  dout;
    modport master (output in_valid, din, out_ready, input in_ready, out_valid, dout);
    modport slave  (input in_valid, din, out_ready, output in_ready, out_valid, dout);
endinterface

// File: rtl/edac_encode_pipe.sv
// edac_encode_pipe: bit-serial CRC followed by Hamming/SECDED encoding, valid/ready on both sides
// clk, rst       : rising-edge clock, synchronous active-high reset
// en             : accept enable, gates in_ready only
// crc_poly       : generator polynomial without its implicit x^CRC_W term
// secded         : append overall parity bit at codeword bit K+P
// io             : in_valid/in_ready/din and out_valid/out_ready/dout handshakes
// busy           : high whenever a word is in flight
module edac_encode_pipe #(
    parameter int DATA_W = 4,
    parameter int CRC_W  = 4,
    parameter int OUT_W  = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic [CRC_W-1:0]   crc_poly,
    input  logic               secded,
    edac_encode_pipe_if.slave  io,
    output logic               busy
);
    localparam int K = DATA_W + CRC_W;

    function automatic int calc_p(input int k);
        int p;
        p = 0;
        for (int i = 0; i < 32; i++) if ((1 << p) < k + p + 1) p++;
        return p;
    endfunction

    localparam int P  = calc_p(K);
    localparam int N  = K + P + 1;
    localparam int CW = DATA_W > 1 ? $clog2(DATA_W) : 1;

    generate
        if (OUT_W < N) begin : g_width
            $error("OUT_W smaller than codeword width");
        end
    endgenerate

    // Data fills non-power-of-two positions in order; each parity bit then
    // folds in every other position carrying its index bit.
    function automatic logic [N-1:0] hamming(input logic [K-1:0] m, input logic s);
        logic [N-1:0] c;
        int k;
        c = '0;
        k = 0;
        for (int pos = 1; pos <= K + P; pos++)
            if ((pos & (pos - 1)) != 0) begin
                c[pos-1] = m[k];
                k++;
            end
        for (int j = 0; j < P; j++)
            for (int pos = 1; pos <= K + P; pos++)
                if (pos != (1 << j) && ((pos >> j) & 1) == 1)
                    c[(1<<j)-1] = c[(1<<j)-1] ^ c[pos-1];
        c[K+P] = s & (^c[K+P-1:0]);
        return c;
    endfunction

    typedef enum logic [1:0] {IDLE, CRC, HAM, OUT} state_t;

    state_t            st, nxt;
    logic [DATA_W-1:0] d, sh;
    logic [CRC_W-1:0]  poly, r;
    logic              sec;
    logic [CW-1:0]     cnt;
    logic              acc, last, fb;

    assign io.in_ready  = (st == IDLE) & en & ~rst;
    assign io.out_valid = st == OUT;
    assign busy         = st != IDLE;
    assign acc          = io.in_valid & io.in_ready;
    assign last         = cnt == CW'(DATA_W - 1);
    // sh walks din MSB-first while d keeps the original word for the message
    assign fb           = sh[DATA_W-1] ^ r[CRC_W-1];

    always_comb begin
        nxt = st;
        unique case (st)
            IDLE: nxt = acc ? CRC : IDLE;
            CRC:  nxt = last ? HAM : CRC;
            HAM:  nxt = OUT;
            OUT:  nxt = io.out_ready ? IDLE : OUT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            st      <= IDLE;
            d       <= '0;
            sh      <= '0;
            poly    <= '0;
            r       <= '0;
            sec     <= 1'b0;
            cnt     <= '0;
            io.dout <= '0;
        end else begin
            st <= nxt;
            if (acc) begin
                d    <= io.din;
                sh   <= io.din;
                poly <= crc_poly;
                sec  <= secded;
                r    <= '0;
                cnt  <= '0;
            end
            if (st == CRC) begin
                sh  <= sh << 1;
                r   <= (r << 1) ^ (fb ? poly : '0);
                cnt <= cnt + 1'b1;
            end
            if (st == HAM) io.dout <= OUT_W'(hamming({d, r}, sec));
        end
    end
endmodule
